// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory request controller: loads, stores and sub-word RMW stores over a valid/ready bus.
// Optional statistics counters are enabled by defining MEM_REQ_STATS_EN.
module mem_req_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        cvalid,
  output logic [31:0] caddr,
  output logic [31:0] cdata,
  output logic        cpu_req_rw,
  input  logic [31:0] dm_out,
  input  logic        cready
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [31:0] req_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, RMW_RD, MERGE, RMW_WR, DONE} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic             cvalid_q;
  logic             rw_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      caddr_q;
  logic [31:0]      cdata_q;
  logic [31:0]      rdata_q;
  logic [31:0]      merge_q;
  logic [1:0]       offs_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [15:0]      wd_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] load_d;
  logic [31:0] merge_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        misaligned;
  logic        subword;
  logic        handshake;
  logic        timeout_hit;

  // Size comes from funct3[1:0] (00 byte, 01 half, else word); funct3[2] selects zero-extension.
  always_comb begin
    misaligned  = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                  (op_funct3[1] && (op_addr[1:0] != 2'b00));
    subword     = !op_funct3[1];
    handshake   = cvalid_q && cready;
    timeout_hit = cvalid_q && !cready && (cnt_q == TO_LAST);
  end

  always_comb begin
    lane_b = dm_out[{offs_q, 3'b000} +: 8];
    lane_h = offs_q[1] ? dm_out[31:16] : dm_out[15:0];
    case (size_q)
      2'b00:   load_d = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_d = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_d = dm_out;
    endcase
  end

  always_comb begin
    merge_d = merge_q;
    if (size_q == 2'b00) merge_d[{offs_q, 3'b000} +: 8] = wd_q[7:0];
    else                 merge_d[{offs_q[1], 4'b0000} +: 16] = wd_q[15:0];
  end

  assign stall = ((state_q == IDLE) && op_valid) ||
                 ((state_q != IDLE) && (state_q != DONE));

  always_ff @(posedge cpu_clk) begin
    if (cpu_rstn) begin
      state_q  <= IDLE;
      cvalid_q <= 1'b0;
      rw_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
      rdata_q  <= '0;
      merge_q  <= '0;
      offs_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cvalid_q && !cready) cnt_q <= cnt_q + CNT_ONE;
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            offs_q <= op_addr[1:0];
            size_q <= op_funct3[1:0];
            uns_q  <= op_funct3[2];
            wd_q   <= op_wdata[15:0];
            if (misaligned) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              caddr_q  <= {op_addr[31:2], 2'b00};
              cvalid_q <= 1'b1;
              cnt_q    <= '0;
              if (op_we && subword) begin
                rw_q    <= 1'b0;
                state_q <= RMW_RD;
              end else begin
                rw_q    <= op_we;
                state_q <= REQ;
                if (op_we) cdata_q <= op_wdata;
              end
            end
          end
        end
        REQ: begin
          if (handshake) begin
            cvalid_q <= 1'b0;
            if (!rw_q) rdata_q <= load_d;
            state_q  <= DONE;
            done_q   <= 1'b1;
          end else if (timeout_hit) begin
            cvalid_q <= 1'b0;
            state_q  <= DONE;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end
        end
        RMW_RD: begin
          if (handshake) begin
            merge_q  <= dm_out;
            cvalid_q <= 1'b0;
            state_q  <= MERGE;
          end else if (timeout_hit) begin
            cvalid_q <= 1'b0;
            state_q  <= DONE;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end
        end
        // The gap cycle here keeps cvalid low between the read and the write.
        MERGE: begin
          cdata_q  <= merge_d;
          rw_q     <= 1'b1;
          cvalid_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= RMW_WR;
        end
        RMW_WR: begin
          if (handshake || timeout_hit) begin
            cvalid_q <= 1'b0;
            state_q  <= DONE;
            done_q   <= 1'b1;
            err_q    <= timeout_hit;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cvalid     = cvalid_q;
  assign caddr      = caddr_q;
  assign cdata      = cdata_q;
  assign cpu_req_rw = rw_q;

`ifdef MEM_REQ_STATS_EN
  logic [31:0] req_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rstn) begin
      req_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (handshake) req_count_q <= req_count_q + 32'd1;
      if (stall) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign req_count   = req_count_q;
  assign stall_count = stall_count_q;
`else
  // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed ops, a spec-level scoreboard checked every cycle.
module tb_mem_req_ctrl;
  localparam int TO = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_we = 1'b0;
  logic [2:0]  op_funct3 = 3'b000;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic [31:0] dm_out = '0;
  logic        cready = 1'b0;
  logic        stall, done, err, cvalid, cpu_req_rw;
  logic [31:0] rdata, caddr, cdata;
`ifdef MEM_REQ_STATS_EN
  logic [31:0] req_count, stall_count;
`endif

  mem_req_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op_valid(op_valid), .op_we(op_we),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall),
    .rdata(rdata), .done(done), .err(err), .cvalid(cvalid), .caddr(caddr),
    .cdata(cdata), .cpu_req_rw(cpu_req_rw), .dm_out(dm_out), .cready(cready)
`ifdef MEM_REQ_STATS_EN
    , .req_count(req_count), .stall_count(stall_count)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour written from the load/store rules with plain shifts and masks.
  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    v = word >> (8 * int'(addr[1:0]));
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b101:  return {16'b0, v[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (f3 == 3'b010) return wdata;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh = 8 * int'(addr[1:0]);
    return (word & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'b001 || f3 == 3'b101) return addr[0];
    if (f3 == 3'b010) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Bus responder: answers after rspDelay wait cycles, or never when rspTieLow is set.
  int          rspDelay = 0;
  int          rspWait = 0;
  bit          rspTieLow = 1'b0;
  bit          rspSpurious = 1'b0;
  logic [31:0] rspWord = '0;

  always @(posedge cpu_clk) begin
    #1;
    if (cvalid && !rspTieLow) begin
      if (rspWait >= rspDelay) begin
        cready = 1'b1;
        dm_out = rspWord;
      end else begin
        cready = 1'b0;
        rspWait++;
      end
    end else begin
      cready  = rspSpurious && !cvalid;
      dm_out  = 32'h5A5A_5A5A;
      rspWait = 0;
    end
  end

  // Scoreboard state shared between the driver and the per-cycle compare process.
  bit          checkEn = 1'b0;
  bit          opActive = 1'b0;
  bit          expErr = 1'b0;
  bit          expIsLoad = 1'b0;
  logic [31:0] expAddr = '0;
  logic [31:0] expWrite = '0;
  logic [31:0] expLoad = '0;
  logic [31:0] modelRdata = '0;
  bit          prevCvalid = 1'b0;
  bit          prevCready = 1'b0;
  bit          prevDone = 1'b0;
  int          waitCnt = 0;
  int          doneCount = 0;

  always @(negedge cpu_clk) begin
    if (checkEn) begin
      if (done && expIsLoad && !expErr) modelRdata = expLoad;
      checkOutput("rdata", rdata, modelRdata);
      checkOutput("stall", 32'(stall), 32'(opActive && !done));
      if (done) checkOutput("errOnDone", 32'(err), 32'(expErr));
      else      checkOutput("errNoDone", 32'(err), 32'd0);
      if (prevDone) checkOutput("donePulse", 32'(done), 32'd0);
      if (prevCvalid) checkOutput("cvalidHold", 32'(cvalid), 32'(!prevCready && waitCnt < TO));
      if (!opActive) checkOutput("cvalidIdle", 32'(cvalid), 32'd0);
      if (cvalid) begin
        checkOutput("caddr", caddr, expAddr);
        if (cpu_req_rw) checkOutput("cdata", cdata, expWrite);
      end
    end
    if (done) doneCount++;
    if (cvalid && !cready) waitCnt++;
    else waitCnt = 0;
    prevCvalid = cvalid;
    prevCready = cready;
    prevDone   = done;
  end

  task automatic setupOp(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word, input int delay, input bit tieLow);
    rspDelay  = delay;
    rspTieLow = tieLow;
    rspWord   = word;
    expAddr   = {addr[31:2], 2'b00};
    expErr    = modelMisaligned(f3, addr) || tieLow;
    expIsLoad = !we;
    expLoad   = modelLoad(word, f3, addr);
    expWrite  = modelStore(word, f3, addr, wdata);
    @(posedge cpu_clk);
    #1;
    op_valid  = 1'b1;
    op_we     = we;
    op_funct3 = f3;
    op_addr   = addr;
    op_wdata  = wdata;
    opActive  = 1'b1;
  endtask

  task automatic applyStimulus(input string name, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] word, input int delay, input bit tieLow,
                               input int expLat, input int expVHigh, input int expRd, input int expWr,
                               output logic [31:0] lastWr);
    int lat, vHigh, gap, rdPh, wrPh;
    bit seenV, finished;
    lat = 0; vHigh = 0; gap = 0; rdPh = 0; wrPh = 0; seenV = 0; finished = 0;
    lastWr = '0;
    setupOp(we, f3, addr, wdata, word, delay, tieLow);
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge cpu_clk);
      if (done) finished = 1;
      else begin
        if (cvalid) begin
          vHigh++;
          seenV = 1;
          if (cpu_req_rw) lastWr = cdata;
          if (cready) begin
            if (cpu_req_rw) wrPh++;
            else rdPh++;
          end
        end else if (seenV) gap++;
        lat++;
      end
    end
    if (!finished) checkOutput({name, "_doneSeen"}, 32'd0, 32'd1);
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_cvalidCycles"}, vHigh, expVHigh);
    checkOutput({name, "_reads"}, rdPh, expRd);
    checkOutput({name, "_writes"}, wrPh, expWr);
    if (expRd == 1 && expWr == 1) checkOutput({name, "_gap"}, gap, 1);
    @(posedge cpu_clk);
    #1;
    op_valid = 1'b0;
    opActive = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] lw;
    int doneBefore;
    bit sawWrite;
`ifdef MEM_REQ_STATS_EN
    logic [31:0] reqBefore;
`endif

    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    checkOutput("rst_cvalid", 32'(cvalid), 32'd0);
    checkOutput("rst_rw", 32'(cpu_req_rw), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_caddr", caddr, 32'd0);
    checkOutput("rst_cdata", cdata, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b0;
    checkEn  = 1'b1;

    $display("[TB] word load with two wait cycles");
    applyStimulus("lw_wait", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0, 4, 3, 1, 0, lw);
    checkOutput("lw_wait_rdata", rdata, 32'hDEADBEEF);

    $display("[TB] sub-word loads");
    applyStimulus("lb13", 0, 3'b000, 32'h13, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lb13_rdata", rdata, 32'hFFFF_FF80);
    applyStimulus("lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lbu13_rdata", rdata, 32'h0000_0080);
    applyStimulus("lhu12", 0, 3'b101, 32'h12, 32'h0, 32'h80FF_1234, 1, 0, 3, 2, 1, 0, lw);
    checkOutput("lhu12_rdata", rdata, 32'h0000_80FF);
    applyStimulus("lh12", 0, 3'b001, 32'h12, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lh12_rdata", rdata, 32'hFFFF_80FF);
    applyStimulus("lb10", 0, 3'b000, 32'h10, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lb10_rdata", rdata, 32'h0000_0034);

    $display("[TB] stores");
`ifdef MEM_REQ_STATS_EN
    reqBefore = req_count;
`endif
    applyStimulus("sh22", 1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h1111_2222, 0, 0, 4, 2, 1, 1, lw);
    checkOutput("sh22_wdata", lw, 32'hABCD_2222);
    checkOutput("sh22_rdata", rdata, 32'h0000_0034);
`ifdef MEM_REQ_STATS_EN
    checkOutput("sh22_reqCount", req_count - reqBefore, 32'd2);
`endif
    rspSpurious = 1'b1;
    applyStimulus("sb21", 1, 3'b000, 32'h21, 32'h0000_00EE, 32'h1122_3344, 1, 0, 6, 4, 1, 1, lw);
    checkOutput("sb21_wdata", lw, 32'h1122_EE44);
    applyStimulus("sw30", 1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 0, 0, 2, 1, 0, 1, lw);
    checkOutput("sw30_wdata", lw, 32'hCAFE_F00D);

    $display("[TB] misaligned accesses");
    applyStimulus("lw06", 0, 3'b010, 32'h06, 32'h0, 32'h0BAD_0BAD, 0, 0, 1, 0, 0, 0, lw);
    checkOutput("lw06_rdata", rdata, 32'h0000_0034);
    applyStimulus("sh23", 1, 3'b001, 32'h23, 32'h1234, 32'h0, 0, 0, 1, 0, 0, 0, lw);
    rspSpurious = 1'b0;

    $display("[TB] timeouts");
    applyStimulus("lw40_to", 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 1, 5, 4, 0, 0, lw);
    checkOutput("lw40_to_rdata", rdata, 32'h0000_0034);
    applyStimulus("sh44_to", 1, 3'b001, 32'h44, 32'h5555, 32'h0, 0, 1, 5, 4, 0, 0, lw);
    applyStimulus("lw44", 0, 3'b010, 32'h44, 32'h0, 32'h0102_0304, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lw44_rdata", rdata, 32'h0102_0304);

    $display("[TB] reset during write phase");
    setupOp(1, 3'b001, 32'h50, 32'h7777, 32'hAAAA_AAAA, 3, 0);
    sawWrite = 0;
    for (int c = 0; c < 20 && !sawWrite; c++) begin
      @(negedge cpu_clk);
      if (cvalid && cpu_req_rw) sawWrite = 1;
    end
    checkOutput("rst6_reachedWrite", 32'(sawWrite), 32'd1);
    doneBefore = doneCount;
    @(posedge cpu_clk);
    #1;
    checkEn  = 1'b0;
    cpu_rstn = 1'b1;
    op_valid = 1'b0;
    opActive = 1'b0;
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    checkOutput("rst6_cvalid", 32'(cvalid), 32'd0);
    checkOutput("rst6_rw", 32'(cpu_req_rw), 32'd0);
    checkOutput("rst6_caddr", caddr, 32'd0);
    checkOutput("rst6_cdata", cdata, 32'd0);
    checkOutput("rst6_rdata", rdata, 32'd0);
    checkOutput("rst6_err", 32'(err), 32'd0);
    @(posedge cpu_clk);
    #1;
    cpu_rstn   = 1'b0;
    modelRdata = '0;
    @(negedge cpu_clk);
    checkOutput("rst6_noDone", doneCount - doneBefore, 32'd0);
    @(posedge cpu_clk);
    #1;
    checkEn = 1'b1;
    applyStimulus("lw60", 0, 3'b010, 32'h60, 32'h0, 32'h1357_9BDF, 0, 0, 2, 1, 1, 0, lw);
    checkOutput("lw60_rdata", rdata, 32'h1357_9BDF);

    repeat (2) @(posedge cpu_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
